// File: rtl/alu_cmd_packetizer_if.sv
// Host, UART byte and response handshakes of the ALU packetizer, bundled for one port.
// slave is the packetizer side and master is the host/UART side.
interface alu_cmd_packetizer_if #(
  parameter int COUNT_W = 4
);
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [7:0]         cmd_opcode_i;
  logic [COUNT_W-1:0] cmd_count_i;
  logic               cmd_rsp_i;
  logic               opnd_valid_i;
  logic               opnd_ready_o;
  logic [31:0]        opnd_data_i;
  logic [7:0]         tx_data_o;
  logic               tx_valid_o;
  logic               tx_ready_i;
  logic [7:0]         rx_data_i;
  logic               rx_valid_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [31:0]        rsp_data_o;
  logic               rsp_err_o;
  logic               busy_o;

  modport slave (
    input  cmd_valid_i, cmd_opcode_i, cmd_count_i, cmd_rsp_i,
    output cmd_ready_o,
    input  opnd_valid_i, opnd_data_i,
    output opnd_ready_o,
    output tx_data_o, tx_valid_o,
    input  tx_ready_i,
    input  rx_data_i, rx_valid_i,
    output rsp_valid_o, rsp_data_o, rsp_err_o,
    input  rsp_ready_i,
    output busy_o
  );

  modport master (
    output cmd_valid_i, cmd_opcode_i, cmd_count_i, cmd_rsp_i,
    input  cmd_ready_o,
    output opnd_valid_i, opnd_data_i,
    input  opnd_ready_o,
    input  tx_data_o, tx_valid_o,
    output tx_ready_i,
    output rx_data_i, rx_valid_i,
    input  rsp_valid_o, rsp_data_o, rsp_err_o,
    output rsp_ready_i,
    input  busy_o
  );
endinterface

// File: rtl/alu_cmd_packetizer.sv
// Frames an ALU command plus operands into a UART byte stream and gathers the 4-byte LE reply.
// First byte valid one cycle after cmd accept; bytes held under tx_ready backpressure; rx never stalls.
module alu_cmd_packetizer #(
  parameter int MAX_OPERANDS   = 8,
  parameter int COUNT_W        = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  alu_cmd_packetizer_if.slave  bus
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, HDR, OPND, WAIT_RSP, RSP_OUT} state_e;

  state_e             state_q, state_d;
  logic [7:0]         opcode_q;
  logic [COUNT_W-1:0] n_q, n_in, opnd_cnt_q;
  logic               rsp_q;
  logic [1:0]         byte_idx_q, rx_idx_q;
  logic [31:0]        word_q, rsp_data_q;
  logic               word_full_q, rsp_err_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [15:0]        len;
  logic               cmd_ready, opnd_ready, tx_valid;
  logic [7:0]         tx_data;
  logic               tx_hs, last_byte, last_word, rx_hit, tmo_hit;

  assign n_in      = (bus.cmd_count_i > COUNT_W'(MAX_OPERANDS)) ? COUNT_W'(MAX_OPERANDS)
                                                                 : bus.cmd_count_i;
  assign len       = (16'(n_q) << 2) + 16'd4;
  assign tx_hs     = tx_valid && bus.tx_ready_i;
  assign last_byte = tx_hs && (byte_idx_q == 2'd3);
  assign last_word = (opnd_cnt_q + COUNT_W'(1)) == n_q;
  assign rx_hit    = (state_q == WAIT_RSP) && bus.rx_valid_i;
  // A byte arriving on the terminal-count cycle takes priority over the timeout.
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (state_q == WAIT_RSP) && !bus.rx_valid_i &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.cmd_valid_i) state_d = HDR;
      HDR:      if (last_byte) state_d = (n_q != '0) ? OPND : (rsp_q ? WAIT_RSP : IDLE);
      OPND:     if (last_byte && last_word) state_d = rsp_q ? WAIT_RSP : IDLE;
      WAIT_RSP: if ((rx_hit && rx_idx_q == 2'd3) || tmo_hit) state_d = RSP_OUT;
      RSP_OUT:  if (bus.rsp_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Byte presented is a pure function of state and index, so it cannot move while stalled.
  always_comb begin
    cmd_ready  = (state_q == IDLE);
    opnd_ready = (state_q == OPND) && !word_full_q;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    unique case (state_q)
      HDR: begin
        tx_valid = 1'b1;
        unique case (byte_idx_q)
          2'd0:    tx_data = opcode_q;
          2'd1:    tx_data = 8'h00;
          2'd2:    tx_data = len[7:0];
          default: tx_data = len[15:8];
        endcase
      end
      OPND: begin
        tx_valid = word_full_q;
        if (word_full_q) tx_data = word_q[{byte_idx_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opcode_q    <= '0;
      n_q         <= '0;
      rsp_q       <= 1'b0;
      byte_idx_q  <= '0;
      opnd_cnt_q  <= '0;
      word_q      <= '0;
      word_full_q <= 1'b0;
      rx_idx_q    <= '0;
      tmo_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.cmd_valid_i) begin
        opcode_q   <= bus.cmd_opcode_i;
        n_q        <= n_in;
        rsp_q      <= bus.cmd_rsp_i;
        byte_idx_q <= '0;
        opnd_cnt_q <= '0;
      end else if (tx_hs) begin
        byte_idx_q <= byte_idx_q + 2'd1;
      end

      if (opnd_ready && bus.opnd_valid_i) begin
        word_q      <= bus.opnd_data_i;
        word_full_q <= 1'b1;
      end else if (state_q == OPND && last_byte) begin
        word_full_q <= 1'b0;
        opnd_cnt_q  <= opnd_cnt_q + COUNT_W'(1);
      end

      if (state_d == WAIT_RSP && state_q != WAIT_RSP) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
        rx_idx_q   <= '0;
      end else if (rx_hit) begin
        rsp_data_q[{rx_idx_q, 3'b000} +: 8] <= bus.rx_data_i;
        rx_idx_q <= rx_idx_q + 2'd1;
      end else if (tmo_hit) begin
        rsp_err_q <= 1'b1;
      end

      if (state_q == WAIT_RSP && !bus.rx_valid_i) tmo_q <= tmo_q + TMO_W'(1);
      else                                        tmo_q <= '0;
    end
  end

  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.opnd_ready_o = opnd_ready;
  assign bus.tx_valid_o   = tx_valid;
  assign bus.tx_data_o    = tx_data;
  assign bus.rsp_valid_o  = (state_q == RSP_OUT);
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.rsp_err_o    = rsp_err_q;
  assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: doc/alu_cmd_packetizer.md
Name: alu_cmd_packetizer

Overview:
- Host-side initiator for the UART ALU packet protocol.
- Accepts a command (opcode, operand count, response-expected flag) plus a stream of 32-bit operands, frames them into a byte stream, and drives a uart_tx-style valid/ready byte interface.
- Collects the ALU's 4-byte little-endian reply from a UART receiver byte stream and presents it as one 32-bit response with an error/timeout flag.
- Sits between a test/host controller and the uart_tx / uart_rx pair, opposite uart_mod.

Parameters:
- MAX_OPERANDS, 8: maximum operands per packet; larger counts are clamped.
- COUNT_W, 4: width of cmd_count_i; must be at least $clog2(MAX_OPERANDS+1).
- TIMEOUT_CYCLES, 100000: idle cycles allowed between response bytes; 0 disables the timeout.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  command accepted when high with cmd_valid_i
- cmd_opcode_i  input  8  opcode byte
- cmd_count_i  input  COUNT_W  number of 32-bit operands
- cmd_rsp_i  input  1  1 = a 4-byte response is expected
- opnd_valid_i  input  1  operand word valid
- opnd_ready_o  output  1  operand word accepted
- opnd_data_i  input  32  operand word
- tx_data_o  output  8  byte to uart_tx
- tx_valid_o  output  1  byte valid
- tx_ready_i  input  1  uart_tx ready
- rx_data_i  input  8  received byte
- rx_valid_i  input  1  single-cycle received-byte strobe; no backpressure
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed
- rsp_data_o  output  32  assembled response
- rsp_err_o  output  1  1 = timeout, data is partial
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset:
  - Single clock domain on clk_i.
  - rst_ni is asynchronous and active-low.
  - While rst_ni is low: state = IDLE; tx_valid_o, tx_data_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o and all counters are 0.
- Ready signals:
  - cmd_ready_o = (state == IDLE).
  - opnd_ready_o = (state == OPND && word register empty).
  - Both are combinational from state.
- Packet format (byte order on the wire):
  - opcode
  - 0x00 (reserved)
  - LEN[7:0]
  - LEN[15:8]
  - operands, each sent as bytes [7:0], [15:8], [23:16], [31:24].
  - LEN = 4 + 4*N, computed in 16 bits.
  - N = min(cmd_count_i, MAX_OPERANDS).
  - N = 0 is legal and produces a header-only packet.
- States:
  - IDLE:
    - On cmd handshake, latch opcode, N and rsp flag; go to HDR.
    - tx_valid_o rises the next cycle with the opcode byte.
  - HDR:
    - Emit 4 header bytes; the byte index advances only on tx_valid_o && tx_ready_i.
    - After the 4th handshake: go to OPND if N > 0, else to WAIT_RSP if the rsp flag is set, else to IDLE.
  - OPND:
    - A word is loaded on opnd handshake; emit its 4 bytes, then mark the register empty.
    - tx_valid_o is low while waiting for a word.
    - After the last byte of operand N: go to WAIT_RSP if the rsp flag is set, else to IDLE.
    - Extra operand words are not consumed.
  - WAIT_RSP:
    - Shift each rx_valid_i byte into rsp_data_o at byte position k (k = 0..3, LSB first).
    - After the 4th byte: go to RSP_OUT with rsp_err_o = 0.
    - The timeout counter clears on state entry and on every rx byte, and increments otherwise.
    - When it reaches TIMEOUT_CYCLES: go to RSP_OUT with rsp_err_o = 1; unreceived bytes are 0.
  - RSP_OUT:
    - rsp_valid_o is high and rsp_data_o/rsp_err_o are stable until rsp_ready_i; then go to IDLE.
- tx handshake rules:
  - Once tx_valid_o is high, tx_data_o is held stable and tx_valid_o does not drop until tx_ready_i.
  - One byte per handshake; back-to-back bytes are allowed, giving 1 byte/cycle max.
- rx rules:
  - rx_valid_i is ignored outside WAIT_RSP; bytes are dropped with no error.
  - rx_valid_i on the same cycle as the timeout terminal count: the byte wins, the counter clears, and there is no timeout.
- Reset mid-operation: the packet is abandoned, and tx_valid_o drops immediately (asynchronous).
- Response register:
  - rsp_data_o is cleared on entry to WAIT_RSP.
  - rsp_data_o is held after the rsp handshake until the next WAIT_RSP entry.

Test Plan:
- Add: opcode 0xAD, count 2, rsp 1, operands 0x00000001, 0x00000002, tx_ready_i = 1.
  - Required tx bytes: AD 00 0C 00 01 00 00 00 02 00 00 00.
  - Then feed rx 03 00 00 00 -> rsp_data_o = 0x00000003, rsp_err_o = 0, busy_o low after the rsp handshake.
- Echo without response: opcode 0xEC, count 1, rsp 0, operand 0x44434241.
  - Required tx bytes: EC 00 08 00 41 42 43 44.
  - Returns to IDLE; rsp_valid_o never asserts; rx bytes injected afterward are ignored.
- Backpressure: toggle tx_ready_i pseudo-randomly and drop opnd_valid_i between words.
  - tx_data_o is stable while tx_valid_o && !tx_ready_i.
  - The byte sequence is identical to the add case.
- Timeout: TIMEOUT_CYCLES = 50, rx AA then BB, then silence.
  - Exactly 50 cycles after BB: rsp_valid_o = 1, rsp_err_o = 1, rsp_data_o = 0x0000BBAA.
- Clamp and empty packets:
  - count 9 with MAX_OPERANDS 8 -> LEN bytes 24 00 and exactly 8 operand words consumed.
  - count 0 -> 4-byte header with LEN 04 00.
- Reset mid-packet: assert rst_ni low after the 6th tx byte.
  - tx_valid_o = 0 and busy_o = 0 asynchronously; cmd_ready_o = 1.
  - A new command after release frames correctly from its opcode byte.
